// File: rtl/inst_encoder.sv
// inst_encoder: sequential MIPS instruction writer for IMEM preload.
// Symbolic requests are encoded and written to consecutive word addresses,
// one registered write per accepted request.
// Optional build macro INST_ENC_CHECK_EN enables the sticky illegal-request flag
// (err). Illegal requests are then written as NOP. Without the macro, err stays 0.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0,  OP_JR   = 4'd1,  OP_J    = 4'd2,  OP_JAL  = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4,  OP_BNE  = 4'd5,  OP_LW   = 4'd6,  OP_SW   = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8,  OP_ADDIU = 4'd9, OP_ANDI = 4'd10, OP_ORI  = 4'd11;
  localparam logic [3:0] OP_XORI  = 4'd12, OP_LUI  = 4'd13;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Map a symbolic request onto its 32-bit MIPS word; unused fields are zero.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [5:0] funct, input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      OP_RTYPE: w = {6'h00, rs, rt, rd, 5'd0, funct};
      OP_JR:    w = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
      OP_J:     w = {6'h02, target};
      OP_JAL:   w = {6'h03, target};
      OP_BEQ:   w = {6'h04, rs, rt, imm};
      OP_BNE:   w = {6'h05, rs, rt, imm};
      OP_LW:    w = {6'h23, rs, rt, imm};
      OP_SW:    w = {6'h2B, rs, rt, imm};
      OP_ADDI:  w = {6'h08, rs, rt, imm};
      OP_ADDIU: w = {6'h09, rs, rt, imm};
      OP_ANDI:  w = {6'h0C, rs, rt, imm};
      OP_ORI:   w = {6'h0D, rs, rt, imm};
      OP_XORI:  w = {6'h0E, rs, rt, imm};
      OP_LUI:   w = {6'h0F, 5'd0, rt, imm};
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

`ifdef INST_ENC_CHECK_EN
  // Requests that would be meaningless or write the zero register.
  function automatic logic is_illegal(input logic [3:0] op, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] funct);
    logic bad;
    bad = 1'b0;
    if (op > OP_LUI) bad = 1'b1;
    if (op == OP_RTYPE && (funct == 6'h08 || rd == 5'd0)) bad = 1'b1;
    if ((op == OP_LW || (op >= OP_ADDI && op <= OP_LUI)) && rt == 5'd0) bad = 1'b1;
    return bad;
  endfunction
`endif

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic                xfer_p0;
  logic                last_p0;
  logic                illegal_p0;
  logic [31:0]         enc_word_p0;

  // A transfer coinciding with start is discarded: the session restarts that cycle.
  assign xfer_p0 = req_valid && req_ready && !start;
  assign last_p0 = xfer_p0 && (count == LAST_CNT);

`ifdef INST_ENC_CHECK_EN
  assign illegal_p0 = is_illegal(req_op, req_rt, req_rd, req_funct);
`else
  assign illegal_p0 = 1'b0;
`endif

  assign enc_word_p0 = illegal_p0 ? 32'h0
                                  : encode(req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target);

  // Session FSM: next state and the state-derived handshake/status outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      LOAD: begin
        busy      = 1'b1;
        req_ready = !full;
        if (finish || last_p0) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = LOAD;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Session bookkeeping: write pointer, word count, full and sticky error.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      ptr   <= BASE;
      count <= '0;
      full  <= 1'b0;
      err   <= 1'b0;
    end else if (xfer_p0) begin
      ptr   <= ptr + PTR_ONE;
      count <= count + CNT_ONE;
      if (last_p0) full <= 1'b1;
      if (illegal_p0) err <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: registered IMEM write, one cycle after acceptance ----
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0;
    end else begin
      imem_we <= xfer_p0;
      if (xfer_p0) begin
        imem_addr  <= ptr;
        imem_wdata <= enc_word_p0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder (DEPTH=4): directed requests with hand-encoded words;
// expected writes are queued by the driver and popped by a write monitor.
module tb_inst_encoder;

  localparam int ADDR_W = 8;

`ifdef INST_ENC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, finish, req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, full, err;
  logic [ADDR_W:0]   count;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .full(full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {24'h0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {24'h0, imem_addr}, {24'h0, e[ADDR_W+31:32]});
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Present one request for one cycle; queue its write if acceptance is expected.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic acc, input logic [7:0] addr,
                      input logic [31:0] word, input logic fin);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_funct = funct; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    finish = fin;
    chk("req_ready", {31'h0, req_ready}, {31'h0, acc});
    if (acc) exp_q.push_back({addr, word});
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0; start = 1'b0; finish = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    req_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_funct = '0; req_imm = '0; req_target = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_we",    {31'h0, imem_we}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_full",  {31'h0, full}, 32'h0);
    chk("rst_err",   {31'h0, err}, 32'h0);
    chk("rst_addr",  {24'h0, imem_addr}, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", {23'h0, count}, 32'h0);
    rst = 1'b0;
    idle();
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // Session 1: single LW
    pulse_start();
    chk("start_busy", {31'h0, busy}, 32'h1);
    send(4'd6, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1, 8'd0, 32'h8C22_0004, 1'b0);
    chk("lw_count", {23'h0, count}, 32'h1);
    idle();

    // Session 2: back-to-back, then fill to DEPTH
    pulse_start();
    chk("restart_count", {23'h0, count}, 32'h0);
    send(4'd8,  5'd0, 5'd8, 5'd0, 6'h0,  16'hFFFF, 26'h0, 1'b1, 8'd0, 32'h2008_FFFF, 1'b0);
    send(4'd13, 5'd9, 5'd1, 5'd0, 6'h0,  16'h1234, 26'h0, 1'b1, 8'd1, 32'h3C01_1234, 1'b0);
    send(4'd0,  5'd1, 5'd2, 5'd3, 6'h20, 16'h0,    26'h0, 1'b1, 8'd2, 32'h0022_1820, 1'b0);
    chk("b2b_count", {23'h0, count}, 32'h3);
    send(4'd1, 5'd31, 5'd7, 5'd5, 6'h3F, 16'hBEEF, 26'h3FF_FFFF, 1'b1, 8'd3, 32'h03E0_0008, 1'b0);
    chk("full_full",  {31'h0, full}, 32'h1);
    chk("full_busy",  {31'h0, busy}, 32'h0);
    chk("full_count", {23'h0, count}, 32'h4);
    send(4'd2, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h010_0000, 1'b0, 8'd0, 32'h0, 1'b0);
    send(4'd2, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h010_0000, 1'b0, 8'd0, 32'h0, 1'b0);

    // Session 3: restart after full, finish coincident with a transfer
    pulse_start();
    chk("reopen_full", {31'h0, full}, 32'h0);
    send(4'd2, 5'd4, 5'd4, 5'd4, 6'h1, 16'h5555, 26'h010_0000, 1'b1, 8'd0, 32'h0810_0000, 1'b0);
    send(4'd5, 5'd3, 5'd4, 5'd0, 6'h0, 16'hFFFE, 26'h0, 1'b1, 8'd1, 32'h1464_FFFE, 1'b1);
    chk("fin_busy",  {31'h0, busy}, 32'h0);
    chk("fin_ready", {31'h0, req_ready}, 32'h0);
    chk("fin_count", {23'h0, count}, 32'h2);
    chk("fin_full",  {31'h0, full}, 32'h0);
    idle();

    // Session 4: illegal op written as NOP; err sticky until start
    pulse_start();
    send(4'd14, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hAAAA, 26'h155_5555, 1'b1, 8'd0, 32'h0, 1'b0);
    chk("op14_err", {31'h0, err}, {31'h0, EXP_ERR});
    send(4'd7, 5'd29, 5'd31, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b1, 8'd1, 32'hAFBF_0010, 1'b0);
    chk("sticky_err", {31'h0, err}, {31'h0, EXP_ERR});
    idle();
    pulse_start();
    chk("start_clr_err", {31'h0, err}, 32'h0);

    // Session 5: reset asserted with a transfer drops that write
    send(4'd3, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF, 1'b1, 8'd0, 32'h0FFF_FFFF, 1'b0);
    req_op = 4'd10; req_rs = 5'd1; req_rt = 5'd2; req_imm = 16'h00FF;
    req_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk("rstdrop_we",    {31'h0, imem_we}, 32'h0);
    chk("rstdrop_busy",  {31'h0, busy}, 32'h0);
    chk("rstdrop_count", {23'h0, count}, 32'h0);
    chk("rstdrop_wdata", imem_wdata, 32'h0);
    repeat (3) idle();
    chk("pending_writes", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
